// File: rtl/phrase_tx_if.sv
// rtl/phrase_tx_if.sv - character stream handshake between phrase_tx and its consumer
interface phrase_tx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/phrase_tx.sv
// rtl/phrase_tx.sv - streams the fixed phrase "I Love You!" a captured number of times
module phrase_tx #(
  parameter int         GAP       = 0,
  parameter logic [7:0] IDLE_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  repeat_n,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  phrase_tx_if.master dout
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] gap_cnt, gap_nx;
  logic       xfer;

  function automatic logic [7:0] phrase_char(input logic [3:0] i);
    case (i)
      4'd0:    phrase_char = 8'h49;
      4'd1:    phrase_char = 8'h20;
      4'd2:    phrase_char = 8'h4C;
      4'd3:    phrase_char = 8'h6F;
      4'd4:    phrase_char = 8'h76;
      4'd5:    phrase_char = 8'h65;
      4'd6:    phrase_char = 8'h20;
      4'd7:    phrase_char = 8'h59;
      4'd8:    phrase_char = 8'h6F;
      4'd9:    phrase_char = 8'h75;
      4'd10:   phrase_char = 8'h21;
      default: phrase_char = IDLE_CHAR;
    endcase
  endfunction

  // data_valid is registered, so a transfer depends on data_ready only through the D inputs
  assign xfer = dout.data_valid && dout.data_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    gap_nx   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_SEND;
          idx_nx   = 4'd0;
          cnt_nx   = (repeat_n == 4'd0) ? 4'd1 : repeat_n;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx < 4'd10) begin
            idx_nx   = idx + 4'd1;
            state_nx = (GAP > 0) ? S_GAP : S_SEND;
            gap_nx   = GAP_LOAD;
          end else if (cnt > 4'd1) begin
            cnt_nx   = cnt - 4'd1;
            idx_nx   = 4'd0;
            state_nx = (GAP > 0) ? S_GAP : S_SEND;
            gap_nx   = GAP_LOAD;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd0) state_nx = S_SEND;
        else                 gap_nx   = gap_cnt - 8'd1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nx = S_IDLE;
    if (state_nx == S_IDLE) begin
      idx_nx = 4'd0;
      cnt_nx = 4'd0;
      gap_nx = 8'd0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= 4'd0;
      cnt             <= 4'd0;
      gap_cnt         <= 8'd0;
      dout.data_valid <= 1'b0;
      dout.data_out   <= IDLE_CHAR;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nx;
      idx             <= idx_nx;
      cnt             <= cnt_nx;
      gap_cnt         <= gap_nx;
      dout.data_valid <= (state_nx == S_SEND);
      dout.data_out   <= (state_nx == S_SEND) ? phrase_char(idx_nx) : IDLE_CHAR;
      busy            <= (state_nx != S_IDLE);
      done            <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_phrase_tx.sv
// tb/tb_phrase_tx.sv - randomized self-checking bench for phrase_tx (GAP=0 and GAP=2 instances)
module tb_phrase_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] repeat_n = 4'd1;
  logic       data_ready = 1'b1;
  int         sel = 0;

  logic busy0, done0, busy2, done2;
  phrase_tx_if if0();
  phrase_tx_if if2();

  assign if0.data_ready = data_ready;
  assign if2.data_ready = data_ready;

  phrase_tx #(.GAP(0), .IDLE_CHAR(8'h20)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .repeat_n(repeat_n),
    .abort(abort && sel == 0), .busy(busy0), .done(done0), .dout(if0));
  phrase_tx #(.GAP(2), .IDLE_CHAR(8'h20)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .repeat_n(repeat_n),
    .abort(abort && sel == 2), .busy(busy2), .done(done2), .dout(if2));

  always #5 clk = ~clk;

  logic       obs_valid, obs_busy, obs_done;
  logic [7:0] obs_data;
  assign obs_valid = (sel == 2) ? if2.data_valid : if0.data_valid;
  assign obs_data  = (sel == 2) ? if2.data_out   : if0.data_out;
  assign obs_busy  = (sel == 2) ? busy2 : busy0;
  assign obs_done  = (sel == 2) ? done2 : done0;

  logic [7:0] phrase_ref [11] = '{8'h49, 8'h20, 8'h4C, 8'h6F, 8'h76, 8'h65,
                                  8'h20, 8'h59, 8'h6F, 8'h75, 8'h21};

  int checks = 0;
  int failures = 0;

  logic       v_log [$];
  logic [7:0] d_log [$];
  logic       dn_log[$];
  logic       b_log [$];
  logic       r_log [$];
  logic [7:0] got   [$];
  bit         timed_out;

  task automatic begin_run(input int s, input logic [3:0] rep);
    @(negedge clk);
    sel = s; repeat_n = rep; data_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Log one negedge sample per cycle and drive the next cycle's inputs; stops two idle cycles after a run
  task automatic collect(input int max_cyc, input int stall_max, input bit scramble,
                         input int start_at, input logic [7:0] abort_chr);
    int  stall = 0;
    int  idle_run = 0;
    bit  seen = 0;
    v_log.delete(); d_log.delete(); dn_log.delete(); b_log.delete(); r_log.delete(); got.delete();
    timed_out = 0;
    for (int c = 0; c < max_cyc; c++) begin
      v_log.push_back(obs_valid); d_log.push_back(obs_data);
      dn_log.push_back(obs_done); b_log.push_back(obs_busy);
      if (obs_busy) seen = 1;
      idle_run = obs_busy ? 0 : idle_run + 1;
      if (seen && idle_run >= 2) begin
        r_log.push_back(data_ready);
        start = 1'b0; abort = 1'b0; data_ready = 1'b1;
        return;
      end
      abort = 1'b0;
      start = (c == start_at);
      if (scramble) repeat_n = 4'($urandom);
      if (stall > 0) begin
        data_ready = 1'b0; stall--;
      end else begin
        data_ready = 1'b1;
        if (stall_max > 0 && $urandom_range(0, 2) == 0) stall = $urandom_range(1, stall_max);
      end
      if (abort_chr != 8'h00 && obs_valid && obs_data == abort_chr) begin
        data_ready = 1'b1; abort = 1'b1;
      end
      r_log.push_back(data_ready);
      if (obs_valid && data_ready) got.push_back(obs_data);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; data_ready = 1'b1;
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      #1;
      checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid sel=%0d got %b want 0", s, obs_valid); end
      checks++; if (obs_data !== 8'h20) begin failures++; $display("FAIL reset_data sel=%0d got %h want 20", s, obs_data); end
      checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL reset_busy sel=%0d got %b want 0", s, obs_busy); end
      checks++; if (obs_done !== 1'b0) begin failures++; $display("FAIL reset_done sel=%0d got %b want 0", s, obs_done); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0;
  endtask

  task automatic test_basic();
    int errs = 0;
    begin_run(0, 4'd1);
    collect(200, 0, 0, -1, 8'h00);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got timeout want completion"); end
    for (int i = 0; i < 11; i++) if (i >= v_log.size() || v_log[i] !== 1'b1) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL basic_valid_window got %0d bad cycles want 0", errs); end
    errs = (got.size() != 11) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL basic_seq got %0d bytes/%0d errs want 11 bytes", got.size(), errs); end
    checks++; if (dn_log.size() < 13 || dn_log[11] !== 1'b1) begin failures++; $display("FAIL basic_done_t12 got %b want 1", (dn_log.size() > 11) ? dn_log[11] : 1'bx); end
    checks++; if (b_log.size() < 13 || b_log[12] !== 1'b0) begin failures++; $display("FAIL basic_busy_t13 got %b want 0", (b_log.size() > 12) ? b_log[12] : 1'bx); end
  endtask

  task automatic test_gap();
    int errs = 0;
    int viol = 0;
    int ndone = 0;
    begin_run(2, 4'd1);
    collect(400, 0, 0, -1, 8'h00);
    errs = (got.size() != 11) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL gap_seq got %0d bytes/%0d errs want 11 bytes", got.size(), errs); end
    for (int i = 0, k = 0; i < v_log.size(); i++) begin
      if (v_log[i] && r_log[i]) begin
        k++;
        if (k < 11) begin
          if (i + 3 >= v_log.size()) viol++;
          else if (v_log[i+1] !== 1'b0 || d_log[i+1] !== 8'h20 || v_log[i+2] !== 1'b0 ||
                   d_log[i+2] !== 8'h20 || v_log[i+3] !== 1'b1) viol++;
        end else if (i + 1 >= dn_log.size() || dn_log[i+1] !== 1'b1) viol++;
      end
    end
    foreach (dn_log[i]) if (dn_log[i]) ndone++;
    checks++; if (viol != 0) begin failures++; $display("FAIL gap_spacing got %0d violations want 0", viol); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL gap_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_stall();
    for (int s = 0; s <= 2; s += 2) begin
      logic [3:0] rep = 4'($urandom_range(1, 2));
      int errs = 0;
      int viol = 0;
      begin_run(s, rep);
      collect(3000, 5, 0, -1, 8'h00);
      errs = (got.size() != 11 * rep) ? 1 : 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL stall_seq sel=%0d got %0d bytes/%0d errs want %0d", s, got.size(), errs, 11 * rep); end
      for (int i = 0; i + 1 < v_log.size(); i++)
        if (v_log[i] && !r_log[i] && !(v_log[i+1] === 1'b1 && d_log[i+1] === d_log[i])) viol++;
      checks++; if (viol != 0) begin failures++; $display("FAIL stall_stable sel=%0d got %0d changes want 0", s, viol); end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] reps [2] = '{4'd0, 4'd3};
    int         sels [2] = '{0, 2};
    for (int t = 0; t < 2; t++) begin
      int want = (reps[t] == 4'd0) ? 11 : 11 * reps[t];
      int errs = 0;
      int ndone = 0;
      begin_run(sels[t], reps[t]);
      collect(3000, 2, 1, -1, 8'h00);
      errs = (got.size() != want) ? 1 : 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
      foreach (dn_log[i]) if (dn_log[i]) ndone++;
      checks++; if (errs != 0) begin failures++; $display("FAIL repeat_seq rep=%0d got %0d bytes/%0d errs want %0d", reps[t], got.size(), errs, want); end
      checks++; if (ndone != 1) begin failures++; $display("FAIL repeat_done rep=%0d got %0d want 1", reps[t], ndone); end
    end
  endtask

  task automatic test_abort();
    int errs = 0;
    int ndone = 0;
    int ai = -1;
    begin_run(0, 4'd2);
    collect(500, 3, 0, -1, 8'h76);
    errs = (got.size() != 5) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL abort_seq got %0d bytes/%0d errs want 5", got.size(), errs); end
    foreach (v_log[i]) if (ai < 0 && v_log[i] && d_log[i] == 8'h76) ai = i;
    checks++; if (ai < 0 || ai + 1 >= v_log.size() || v_log[ai+1] !== 1'b0 || b_log[ai+1] !== 1'b0) begin
      failures++; $display("FAIL abort_idle got abort_at=%0d want idle next cycle", ai); end
    foreach (dn_log[i]) if (dn_log[i]) ndone++;
    checks++; if (ndone != 0) begin failures++; $display("FAIL abort_done got %0d pulses want 0", ndone); end
    begin_run(0, 4'd1);
    collect(300, 2, 0, -1, 8'h00);
    errs = (got.size() != 11) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL abort_restart got %0d bytes/%0d errs want 11", got.size(), errs); end
  endtask

  task automatic test_busy_start();
    int ndone = 0;
    int late = 0;
    begin_run(2, 4'd1);
    collect(400, 0, 0, 5, 8'h00);
    foreach (dn_log[i]) if (dn_log[i]) ndone++;
    for (int i = 0; i < 6; i++) begin
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) late++;
      @(negedge clk);
    end
    checks++; if (got.size() != 11) begin failures++; $display("FAIL busy_start_len got %0d want 11", got.size()); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL busy_start_done got %0d want 1", ndone); end
    checks++; if (late != 0) begin failures++; $display("FAIL busy_start_rerun got %0d busy cycles want 0", late); end
  endtask

  task automatic test_reset_gap();
    int n = 0;
    int late = 0;
    int errs = 0;
    begin_run(2, 4'd2);
    while (!(obs_valid === 1'b0 && obs_busy === 1'b1) && n < 50) begin
      @(negedge clk); n++;
    end
    checks++; if (n >= 50) begin failures++; $display("FAIL rgap_reach got timeout want gap state"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs_valid !== 1'b0 || obs_data !== 8'h20) begin failures++; $display("FAIL rgap_data got v=%b d=%h want v=0 d=20", obs_valid, obs_data); end
    checks++; if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin failures++; $display("FAIL rgap_flags got busy=%b done=%b want 0 0", obs_busy, obs_done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL rgap_wait got %0d active cycles want 0", late); end
    begin_run(2, 4'd1);
    collect(400, 0, 0, -1, 8'h00);
    errs = (got.size() != 11) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== phrase_ref[i % 11]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL rgap_restart got %0d bytes/%0d errs want 11", got.size(), errs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_repeat();
    test_abort();
    test_busy_start();
    test_reset_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phrase_tx.md
PHRASE_TX -- requirements
Module: phrase_tx

Interface
REQ-001 Parameter GAP, default 0: idle cycles inserted after each accepted character, range 0..255.
REQ-002 Parameter IDLE_CHAR, default 8'h20: value driven on data_out when no character is pending.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 repeat_n  input  4  number of phrase repetitions, captured at start; 0 is treated as 1.
REQ-007 abort  input  1  synchronous cancel of the transmission in progress.
REQ-008 data_ready  input  1  downstream accepts data_out this cycle when data_valid is also high.
REQ-009 data_out  output  8  current ASCII character.
REQ-010 data_valid  output  1  data_out holds a character awaiting acceptance.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last character of the last repetition is accepted.

Function
REQ-013 The phrase SHALL be the 11 bytes "I", " ", "L", "o", "v", "e", " ", "Y", "o", "u", "!" (8'h49 20 4C 6F 76 65 20 59 6F 75 21), indexed 0..10.
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DONE, with a 4-bit character index and a 4-bit remaining-repetition counter.
REQ-015 IDLE: data_valid=0, data_out=IDLE_CHAR, busy=0. If start=1, go to SEND with index=0 and count=max(repeat_n,1); data_valid=1 with 8'h49 on the next cycle, giving a latency of 1.
REQ-016 SEND: data_valid=1 and data_out=phrase[index]. Both SHALL remain stable while data_ready=0, with no timeout.
REQ-017 A transfer SHALL occur in a cycle where data_valid=1 and data_ready=1; exactly one character is consumed per transfer.
REQ-018 On a transfer with index<10: index+1. Next state is GAP if GAP>0; otherwise stay in SEND, so a back-to-back transfer every cycle is possible when data_ready is held high.
REQ-019 On a transfer with index=10 and count>1: decrement count, set index=0, then go to GAP (if GAP>0) or SEND.
REQ-020 On a transfer with index=10 and count=1: go to DONE.
REQ-021 GAP: data_valid=0 and data_out=IDLE_CHAR for exactly GAP cycles, then SEND.
REQ-022 DONE: done=1 and data_valid=0 for one cycle, then IDLE; busy=1 during DONE.
REQ-023 start while busy=1 SHALL be ignored, and repeat_n changes after capture SHALL have no effect.
REQ-024 abort=1 in SEND, GAP or DONE: next state IDLE, data_valid=0, done not asserted. This applies even if a transfer occurs in the same cycle; that character counts as delivered.
REQ-025 abort in IDLE SHALL have no effect; abort has priority over start in IDLE.
REQ-026 The character counter SHALL never exceed 10 and the repetition counter SHALL never underflow; illegal state encodings SHALL return to IDLE on the next cycle.
REQ-027 All outputs SHALL be registered, with no combinational path from data_ready to data_valid or data_out.

Reset
REQ-028 While rst_n=0: state=IDLE, data_valid=0, data_out=IDLE_CHAR, busy=0, done=0, index=0, count=0.
REQ-029 A reset mid-transmission SHALL discard the phrase; after release the block waits for a new start.

Verification
REQ-030 GAP=0, repeat_n=1, data_ready held 1, start pulse at cycle t -> data_valid=1 at t+1..t+11 with bytes 49 20 4C 6F 76 65 20 59 6F 75 21, done=1 at t+12, busy=0 at t+13.
REQ-031 GAP=2, data_ready=1 -> each accepted character is followed by 2 cycles with data_valid=0 and data_out=8'h20; total 11 transfers; done follows the final "!".
REQ-032 data_ready deasserted randomly for 0..5 cycles -> data_out never changes while data_valid=1 and data_ready=0; the sequence is still exactly 11 bytes in order.
REQ-033 repeat_n=0, then repeat_n=3 -> 11 and 33 transfers respectively, with one done pulse per run.
REQ-034 abort asserted during the transfer of "v" -> next cycle IDLE, data_valid=0, done never asserted; a new start restarts at "I".
REQ-035 rst_n pulsed low during GAP, and start asserted while busy -> reset values per REQ-028; the mid-run start produces no second phrase.
